// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the VGA timing generator to the pixel/framebuffer pipeline.
// The generator drives it through the master modport; consumers use the slave modport.
interface vga_timing_gen_if #(
   parameter int CNT_W   = 10,
   parameter int FRAME_W = 8
);
   logic               pix_ce;
   logic [CNT_W-1:0]   h_count;
   logic [CNT_W-1:0]   v_count;
   logic               hsync;
   logic               vsync;
   logic               de;
   logic               line_start;
   logic               frame_start;
   logic [FRAME_W-1:0] frame_count;

   modport master (
      output pix_ce, h_count, v_count, hsync, vsync, de,
             line_start, frame_start, frame_count
   );

   modport slave (
      input  pix_ce, h_count, v_count, hsync, vsync, de,
             line_start, frame_start, frame_count
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Produces a pixel clock-enable, counters and zero-latency sync/de/strobe decodes.
module vga_timing_gen #(
   parameter int CLK_DIV   = 2,
   parameter int H_VIS     = 640,
   parameter int H_FP      = 16,
   parameter int H_SP      = 96,
   parameter int H_BP      = 48,
   parameter int V_VIS     = 480,
   parameter int V_FP      = 10,
   parameter int V_SP      = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int CNT_W     = 10,
   parameter int FRAME_W   = 8
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic               en,
   vga_timing_gen_if.master   vga
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SP + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SP + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_B = CNT_W'(H_VIS + H_FP);
   localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_VIS + H_FP + H_SP - 1);
   localparam logic [CNT_W-1:0] V_SYNC_B = CNT_W'(V_VIS + V_FP);
   localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_VIS + V_FP + V_SP - 1);
   localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
   localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   if (CLK_DIV < 1 || H_VIS < 1 || H_FP < 1 || H_SP < 1 || H_BP < 1 ||
       V_VIS < 1 || V_FP < 1 || V_SP < 1 || V_BP < 1) begin : g_bad_timing
      $error("vga_timing_gen: every timing parameter and CLK_DIV must be >= 1");
   end
   if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_width
      $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
   end

   logic [DIV_W-1:0]   div_cnt;
   logic [CNT_W-1:0]   h_count;
   logic [CNT_W-1:0]   v_count;
   logic [FRAME_W-1:0] frame_count;
   logic               running;
   logic               pix_ce;
   logic               line_start;

   assign pix_ce = en && (div_cnt == DIV_LAST);

   // All state holds while en is low; reset wins over everything.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         div_cnt     <= '0;
         h_count     <= '0;
         v_count     <= '0;
         frame_count <= '0;
         running     <= 1'b0;
      end else if (en) begin
         div_cnt <= pix_ce ? '0 : div_cnt + 1'b1;
         if (pix_ce) begin
            running <= 1'b1;
            if (h_count == H_LAST) begin
               h_count <= '0;
               if (v_count == V_LAST) begin
                  v_count     <= '0;
                  frame_count <= frame_count + 1'b1;
               end else begin
                  v_count <= v_count + 1'b1;
               end
            end else begin
               h_count <= h_count + 1'b1;
            end
         end
      end
   end

   // Decodes describe the pixel currently addressed, so no extra pipeline delay.
   assign line_start      = pix_ce && (h_count == '0);
   assign vga.pix_ce      = pix_ce;
   assign vga.h_count     = h_count;
   assign vga.v_count     = v_count;
   assign vga.frame_count = frame_count;
   assign vga.line_start  = line_start;
   assign vga.frame_start = line_start && (v_count == '0);
   assign vga.hsync       = (h_count >= H_SYNC_B && h_count <= H_SYNC_E) ? HSYNC_POL : ~HSYNC_POL;
   assign vga.vsync       = (v_count >= V_SYNC_B && v_count <= V_SYNC_E) ? VSYNC_POL : ~VSYNC_POL;
   assign vga.de          = running && (h_count < H_VIS_C) && (v_count < V_VIS_C);

endmodule
